// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller around the Adder1bit full adder cell
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-1:0] s_cat;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit, c_bit;
  logic             last;

  Adder1bit u_cell (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (carry),
    .S   (s_bit),
    .Cout(c_bit)
  );

  // s_sh keeps only the upper sum bits; the newest cell output is prepended on the fly
  assign s_cat = {s_bit, s_sh};
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: begin
        busy = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          s_sh  <= s_cat[WIDTH-1:1];
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= c_bit;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= s_cat;
            cout <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf  <= carry ^ c_bit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module Adder1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=2)
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst8, start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       rst2, start2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned sum and two's-complement overflow of an w-bit add
  function automatic int ref_total(input int x, input int y, input int c);
    return x + y + c;
  endfunction

  function automatic int ref_ovf(input int x, input int y, input int c, input int w);
    int half, sx, sy, t;
    half = 1 << (w - 1);
    sx = (x >= half) ? x - 2 * half : x;
    sy = (y >= half) ? y - 2 * half : y;
    t  = sx + sy + c;
    return ((t >= half) || (t < -half)) ? 1 : 0;
  endfunction

  // One WIDTH=8 add; operands and start are scrambled while busy when 'noisy' is set
  task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic c, input bit noisy);
    int busy_cycles, cycles, total;
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_cycles = 0;
    cycles = 0;
    while (!done8 && cycles < 40) begin
      if (busy8) busy_cycles++;
      if (noisy) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    start8 = 1'b0;
    total = ref_total(int'(x), int'(y), int'(c));
    check("done8_seen", 32'(done8), 32'(1));
    check("busy8_cycles", 32'(busy_cycles), 32'(8));
    check("sum8", 32'(sum8), 32'(total & 8'hFF));
    check("cout8", 32'(cout8), 32'((total >> 8) & 1));
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf8", 32'(ovf8), 32'(ref_ovf(int'(x), int'(y), int'(c), 8)));
`endif
    @(negedge clk);
    check("done8_one_cycle", 32'(done8), 32'(0));
    check("sum8_hold", 32'(sum8), 32'(total & 8'hFF));
  endtask

  task automatic add2(input logic [1:0] x, input logic [1:0] y, input logic c);
    int busy_cycles, cycles, total;
    @(negedge clk);
    a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    busy_cycles = 0;
    cycles = 0;
    while (!done2 && cycles < 20) begin
      if (busy2) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    total = ref_total(int'(x), int'(y), int'(c));
    check("done2_seen", 32'(done2), 32'(1));
    check("busy2_cycles", 32'(busy_cycles), 32'(2));
    check("sum2", 32'(sum2), 32'(total & 3));
    check("cout2", 32'(cout2), 32'((total >> 2) & 1));
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf2", 32'(ovf2), 32'(ref_ovf(int'(x), int'(y), int'(c), 2)));
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses[$];
    int k, guard;
    bit saw_done;

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'(0));
    check("rst_done8", 32'(done8), 32'(0));
    check("rst_sum8", 32'(sum8), 32'(0));
    check("rst_cout8", 32'(cout8), 32'(0));
    check("rst_busy2", 32'(busy2), 32'(0));
    check("rst_sum2", 32'(sum2), 32'(0));
    rst8 = 1'b0; rst2 = 1'b0;

    add8(8'h5A, 8'h3C, 1'b0, 1'b0);
    add8(8'hFF, 8'h01, 1'b0, 1'b0);
    add8(8'hFF, 8'hFF, 1'b1, 1'b0);
    add8(8'h7F, 8'h01, 1'b0, 1'b0);
    add8(8'h80, 8'hFF, 1'b0, 1'b0);
    add8(8'h05, 8'h03, 1'b0, 1'b0);

    // Sum/cout must hold across idle cycles
    repeat (5) @(negedge clk);
    check("idle_hold_sum8", 32'(sum8), 32'(8'h08));
    check("idle_hold_cout8", 32'(cout8), 32'(0));

    for (int i = 0; i < 25; i++)
      add8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

    // Start held high: one add per WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done8) begin
        pulses.push_back(t);
        check("held_sum8", 32'(sum8), 32'(8'h30));
      end
    end
    start8 = 1'b0;
    check("held_pulse_count", 32'(pulses.size() >= 3), 32'(1));
    for (int i = 1; i < pulses.size(); i++)
      check("held_interval", 32'(pulses[i] - pulses[i-1]), 32'(10));
    guard = 0;
    while ((busy8 || done8) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("held_drain", 32'(busy8 | done8), 32'(0));

    // start/a disturbance at SHIFT cycle 3 is ignored
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 1;
    guard = 0;
    while (!done8 && guard < 30) begin
      if (k == 3) begin start8 = 1'b1; a8 = 8'hAA; end
      else start8 = 1'b0;
      @(negedge clk);
      k++;
      guard++;
    end
    start8 = 1'b0;
    check("disturb_done8", 32'(done8), 32'(1));
    check("disturb_sum8", 32'(sum8), 32'(8'h10));
    check("disturb_cout8", 32'(cout8), 32'(0));
    @(negedge clk);
    check("disturb_no_requeue", 32'(busy8), 32'(0));

    // Reset at SHIFT cycle 4 abandons the add
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("midrst_busy8", 32'(busy8), 32'(0));
    check("midrst_sum8", 32'(sum8), 32'(0));
    check("midrst_cout8", 32'(cout8), 32'(0));
    saw_done = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (done8 || busy8) saw_done = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(saw_done), 32'(0));
    add8(8'h96, 8'h6A, 1'b1, 1'b0);

    // Exhaustive WIDTH=2
    for (int v = 0; v < 32; v++)
      add2(2'(v), 2'(v >> 2), 1'(v >> 4));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
